matmul_chunk_sequencer: RTL and testbench
=========================================

// Module: matmul_chunk_sequencer
// PURPOSE
//  Sequencing controller for the chunked vector-matrix engine. Gathers a serial element stream into one
//  input vector, serves it to the engine WorkingRegs elements per chunk (advance/rewind on engine
//  strobes), collects OutVecLength results and drains them as a serial stream to the next layer.
// PARAMETERS
//  InVecLength   8  elements per input vector; must be a multiple of WorkingRegs
//  OutVecLength  3  elements per output vector (= engine req_chunk_out strobes per vector)
//  WorkingRegs   4  chunk width in elements
//  NBits         8  signed element width
// PORTS
//  clk_in             in   1                 single clock, all logic rising edge
//  rst_in             in   1                 synchronous, active-low reset
//  in_valid           in   1                 upstream element valid
//  in_data            in   NBits             upstream element (signed)
//  in_ready           out  1                 element accepted when in_valid&in_ready
//  mm_data_ready      out  1                 input vector loaded; engine may start
//  mm_chunk           out  WorkingRegs*NBits chunk at chunk pointer; element i in bits [i*NBits+:NBits]
//  mm_req_chunk_in    in   1                 advance chunk pointer
//  mm_req_chunk_ptr_rst in 1                 rewind chunk pointer to 0
//  mm_req_chunk_out   in   1                 capture mm_write_out_data as next output element
//  mm_write_out_data  in   NBits             engine result element
//  mm_out_vector_valid in  1                 engine finished the whole vector
//  out_valid          out  1                 downstream element valid
//  out_data           out  NBits             downstream element
//  out_ready          in   1                 downstream accepts when out_valid&out_ready
//  seq_error          out  1                 sticky protocol error
// BEHAVIOUR
//  - Reset (rst_in==0 at edge): all outputs 0, pointers 0, input FSM FILL, output FSM COLLECT, seq_error 0.
//  - Input FSM: FILL -> LOADED -> BUSY -> FILL.
//    FILL: in_ready=1; element k written to in_buf[k]; on accepting element InVecLength-1 -> LOADED next cycle.
//    LOADED: in_ready=0; mm_data_ready=1 iff output FSM is COLLECT and out_buf empty; first
//      mm_req_chunk_in or mm_out_vector_valid seen -> BUSY (mm_data_ready drops next cycle).
//    BUSY: mm_data_ready=0; mm_out_vector_valid -> FILL next cycle.
//  - Chunk pointer cp (0..InVecLength/WorkingRegs-1): mm_chunk = in_buf[cp*WorkingRegs +: WorkingRegs],
//    registered, valid the cycle after the strobe (single-cycle FIFO timing). mm_req_chunk_in: cp+1,
//    wraps to 0 after last chunk. mm_req_chunk_ptr_rst wins over simultaneous mm_req_chunk_in (cp=0).
//    Strobes ignored in FILL; cp forced 0 on entry to LOADED.
//  - Output FSM: COLLECT -> DRAIN -> COLLECT. COLLECT: mm_req_chunk_out writes out_buf[op], op++.
//    op reaching OutVecLength, or mm_out_vector_valid, -> DRAIN. Valid asserted with the final
//    strobe counts that strobe first.
//    DRAIN: out_valid=1, out_data=out_buf[dp]; dp++ per handshake; last handshake -> COLLECT, op=dp=0.
//  - Errors (seq_error set, sticky until reset): mm_req_chunk_out in DRAIN (data dropped);
//    mm_out_vector_valid with op!=OutVecLength; mm_out_vector_valid outside BUSY/LOADED.
//  - Latency: last input element -> mm_data_ready: 1 cycle. Final strobe -> out_valid: 1 cycle.
//  - Throughput: with out_ready held 1, next mm_data_ready no earlier than OutVecLength cycles after DRAIN entry.
//  - No arithmetic; data passed bit-exact, sign preserved.
// CONFIGURATION
//  SEQ_PINGPONG_EN defined: two input buffers. FILL of buffer B runs while engine is BUSY on A.
//    in_ready stays 1 except when both buffers full. On mm_out_vector_valid, a full buffer B goes
//    straight to LOADED (mm_data_ready may re-assert the next cycle, gated as above).
//  Not defined: one buffer; in_ready=0 from LOADED until return to FILL.
// TESTING (InVecLength=8, OutVecLength=3, WorkingRegs=4, NBits=8)
//  1 reset: drive rst_in=0 mid-FILL (5 elements in) -> in_ready=1, all other outputs 0; next vector
//    restarts at element 0.
//  2 feed 1..8 -> mm_data_ready=1 next cycle; mm_chunk={4,3,2,1}; req_chunk_in -> {8,7,6,5};
//    req_chunk_in -> wraps to {4,3,2,1}.
//  3 req_chunk_in and req_chunk_ptr_rst same cycle at cp=0 -> cp stays 0 (rst wins).
//  4 strobe outs -7,0,127 then out_vector_valid -> out stream -7,0,127 in order; out_ready toggled
//    1/0 -> no loss or duplication.
//  5 4th req_chunk_out during DRAIN -> seq_error=1 and held; out_vector_valid after 2 strobes ->
//    seq_error=1.
//  6 SEQ_PINGPONG_EN: stream 16 elements back-to-back while engine is BUSY -> in_ready stays 1 for
//    elements 9-16; vector 2 loads immediately after out_vector_valid. Macro off: in_ready=0 over the
//    same window.

Source files
------------

// File: rtl/matmul_chunk_sequencer.sv
// Chunk sequencer for the vector-matrix engine: gathers an input vector, serves it chunk by chunk,
// collects results and drains them serially. Define SEQ_PINGPONG_EN for double-buffered input.
module matmul_chunk_sequencer #(
    parameter int InVecLength  = 8,
    parameter int OutVecLength = 3,
    parameter int WorkingRegs  = 4,
    parameter int NBits        = 8
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         in_valid,
    input  logic [NBits-1:0]             in_data,
    output logic                         in_ready,
    output logic                         mm_data_ready,
    output logic [WorkingRegs*NBits-1:0] mm_chunk,
    input  logic                         mm_req_chunk_in,
    input  logic                         mm_req_chunk_ptr_rst,
    input  logic                         mm_req_chunk_out,
    input  logic [NBits-1:0]             mm_write_out_data,
    input  logic                         mm_out_vector_valid,
    output logic                         out_valid,
    output logic [NBits-1:0]             out_data,
    input  logic                         out_ready,
    output logic                         seq_error
);

    localparam int NumChunks = InVecLength / WorkingRegs;
    localparam int CpW       = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam int WpW       = (InVecLength > 1) ? $clog2(InVecLength) : 1;
    localparam int OpW       = $clog2(OutVecLength + 1);
`ifdef SEQ_PINGPONG_EN
    localparam bit PingPong  = 1'b1;
    localparam int NumBufs   = 2;
`else
    localparam bit PingPong  = 1'b0;
    localparam int NumBufs   = 1;
`endif
    localparam int BufIdxW   = (NumBufs * InVecLength > 1) ? $clog2(NumBufs * InVecLength) : 1;

    localparam logic [1:0] FILL    = 2'd0;
    localparam logic [1:0] LOADED  = 2'd1;
    localparam logic [1:0] BUSY    = 2'd2;
    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] DRAIN   = 1'b1;

    logic [NBits-1:0] in_buf [NumBufs*InVecLength];
    logic [NBits-1:0] out_buf [OutVecLength];

    logic [1:0]       in_state_reg, in_state_next;
    logic [WpW-1:0]   wp_reg;
    logic [CpW-1:0]   cp_reg, cp_next;
    logic             wsel_reg, wsel_next;
    logic             esel_reg, esel_next;
    logic             spare_full_reg, spare_full_next;
    logic [WorkingRegs*NBits-1:0] chunk_next, mm_chunk_reg;

    logic [0:0]       out_state_reg, out_state_next;
    logic [OpW-1:0]   op_reg, op_next, op_eff, dp_reg, dp_next;
    logic             seq_error_reg;

    logic accept, last_in, spare_done, strobe_c, drain_last, err_set;
    logic [BufIdxW-1:0] wr_idx, chunk_base;

`ifdef SEQ_PINGPONG_EN
    // Stall only while the engine holds one buffer and the spare is already full.
    assign in_ready = (in_state_reg == FILL) || !spare_full_reg;
`else
    assign in_ready = (in_state_reg == FILL);
`endif

    assign accept     = in_valid && in_ready;
    assign last_in    = accept && (wp_reg == WpW'(InVecLength - 1));
    assign spare_done = last_in && (in_state_reg != FILL);
    assign wr_idx     = BufIdxW'(int'(wsel_reg) * InVecLength + int'(wp_reg));

    always_comb begin
        in_state_next   = in_state_reg;
        wsel_next       = wsel_reg;
        esel_next       = esel_reg;
        spare_full_next = spare_full_reg;
        if (spare_done) spare_full_next = 1'b1;
        case (in_state_reg)
            FILL: begin
                if (last_in) begin
                    in_state_next = LOADED;
                    esel_next     = wsel_reg;
                    if (PingPong) wsel_next = ~wsel_reg;
                end
            end
            LOADED: begin
                if (mm_req_chunk_in || mm_out_vector_valid) in_state_next = BUSY;
            end
            BUSY: begin
                if (mm_out_vector_valid) begin
                    if (PingPong && (spare_full_reg || spare_done)) begin
                        in_state_next   = LOADED;
                        esel_next       = wsel_reg;
                        wsel_next       = ~wsel_reg;
                        spare_full_next = 1'b0;
                    end else begin
                        in_state_next = FILL;
                    end
                end
            end
            default: in_state_next = FILL;
        endcase
    end

    // Pointer is frozen during FILL and rewound whenever a fresh vector becomes LOADED.
    always_comb begin
        cp_next = cp_reg;
        if (in_state_reg == FILL || (in_state_next == LOADED && in_state_reg != LOADED))
            cp_next = '0;
        else if (mm_req_chunk_ptr_rst)
            cp_next = '0;
        else if (mm_req_chunk_in)
            cp_next = (cp_reg == CpW'(NumChunks - 1)) ? '0 : cp_reg + CpW'(1);
    end

    assign chunk_base = BufIdxW'(int'(esel_next) * InVecLength + int'(cp_next) * WorkingRegs);

    generate
        for (genvar gi = 0; gi < WorkingRegs; gi++) begin : g_chunk
            assign chunk_next[gi*NBits +: NBits] = in_buf[chunk_base + BufIdxW'(gi)];
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (accept) in_buf[wr_idx] <= in_data;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            in_state_reg   <= FILL;
            wp_reg         <= '0;
            cp_reg         <= '0;
            wsel_reg       <= 1'b0;
            esel_reg       <= 1'b0;
            spare_full_reg <= 1'b0;
            mm_chunk_reg   <= '0;
        end else begin
            in_state_reg   <= in_state_next;
            cp_reg         <= cp_next;
            wsel_reg       <= wsel_next;
            esel_reg       <= esel_next;
            spare_full_reg <= spare_full_next;
            if (accept) wp_reg <= last_in ? '0 : wp_reg + WpW'(1);
            // Refreshed every non-FILL cycle so a same-edge buffer write is picked up one cycle later.
            if (in_state_next != FILL) mm_chunk_reg <= chunk_next;
        end
    end

    // A strobe that arrives together with vector-valid is counted before the check.
    assign strobe_c   = mm_req_chunk_out && (out_state_reg == COLLECT);
    assign op_eff     = op_reg + OpW'(strobe_c);
    assign drain_last = (out_state_reg == DRAIN) && out_ready && ((dp_reg + OpW'(1)) == op_reg);

    always_comb begin
        out_state_next = out_state_reg;
        op_next        = op_reg;
        dp_next        = dp_reg;
        if (out_state_reg == COLLECT) begin
            op_next = op_eff;
            if (op_eff == OpW'(OutVecLength) || (mm_out_vector_valid && op_eff != '0))
                out_state_next = DRAIN;
        end else if (out_ready) begin
            if (drain_last) begin
                out_state_next = COLLECT;
                op_next        = '0;
                dp_next        = '0;
            end else begin
                dp_next = dp_reg + OpW'(1);
            end
        end
    end

    assign err_set = (mm_req_chunk_out && out_state_reg == DRAIN)
                  || (mm_out_vector_valid && op_eff != OpW'(OutVecLength))
                  || (mm_out_vector_valid && !(in_state_reg == BUSY || in_state_reg == LOADED));

    always_ff @(posedge clk_in) begin
        if (strobe_c) out_buf[op_reg] <= mm_write_out_data;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            out_state_reg <= COLLECT;
            op_reg        <= '0;
            dp_reg        <= '0;
            seq_error_reg <= 1'b0;
        end else begin
            out_state_reg <= out_state_next;
            op_reg        <= op_next;
            dp_reg        <= dp_next;
            if (err_set) seq_error_reg <= 1'b1;
        end
    end

    assign mm_data_ready = (in_state_reg == LOADED) && (out_state_reg == COLLECT) && (op_reg == '0);
    assign mm_chunk      = mm_chunk_reg;
    assign out_valid     = (out_state_reg == DRAIN);
    assign out_data      = (out_state_reg == DRAIN) ? out_buf[dp_reg] : '0;
    assign seq_error     = seq_error_reg;

endmodule

// File: tb/tb_matmul_chunk_sequencer.sv
// Scoreboard bench for matmul_chunk_sequencer; expectations follow SEQ_PINGPONG_EN when defined.
module tb_matmul_chunk_sequencer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mm_data_ready;
    logic [31:0] mm_chunk;
    logic        mm_req_chunk_in;
    logic        mm_req_chunk_ptr_rst;
    logic        mm_req_chunk_out;
    logic [7:0]  mm_write_out_data;
    logic        mm_out_vector_valid;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        seq_error;

`ifdef SEQ_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    logic [7:0]  out_q [$];
    logic [31:0] chunk_q [$];

    always #5 clk_in = ~clk_in;

    matmul_chunk_sequencer #(
        .InVecLength(8), .OutVecLength(3), .WorkingRegs(4), .NBits(8)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mm_data_ready(mm_data_ready), .mm_chunk(mm_chunk),
        .mm_req_chunk_in(mm_req_chunk_in), .mm_req_chunk_ptr_rst(mm_req_chunk_ptr_rst),
        .mm_req_chunk_out(mm_req_chunk_out), .mm_write_out_data(mm_write_out_data),
        .mm_out_vector_valid(mm_out_vector_valid),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .seq_error(seq_error)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        in_valid = 1'b0; in_data = '0;
        mm_req_chunk_in = 1'b0; mm_req_chunk_ptr_rst = 1'b0; mm_req_chunk_out = 1'b0;
        mm_write_out_data = '0; mm_out_vector_valid = 1'b0; out_ready = 1'b0;
        out_q.delete();
        chunk_q.delete();
        tick();
        rst_in = 1'b1;
    endtask

    task automatic feed(input int first, input int count);
        for (int k = 0; k < count; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(first + k);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_chunk(input bit adv, input bit rew, input logic [31:0] exp_chunk);
        chunk_q.push_back(exp_chunk);
        mm_req_chunk_in = adv;
        mm_req_chunk_ptr_rst = rew;
        tick();
        mm_req_chunk_in = 1'b0;
        mm_req_chunk_ptr_rst = 1'b0;
        begin
            logic [31:0] exp;
            exp = chunk_q.pop_front();
            n_vec++;
            $display("chunk adv=%0b rew=%0b -> %h", adv, rew, mm_chunk);
            if (mm_chunk !== exp) begin
                n_miss++;
                $display("FAIL chunk: got %h want %h", mm_chunk, exp);
            end
        end
    endtask

    task automatic strobe_out(input logic [7:0] v, input bit with_valid, input bit expect_kept);
        if (expect_kept) out_q.push_back(v);
        mm_req_chunk_out = 1'b1;
        mm_write_out_data = v;
        mm_out_vector_valid = with_valid;
        tick();
        mm_req_chunk_out = 1'b0;
        mm_out_vector_valid = 1'b0;
    endtask

    task automatic vec_valid_pulse();
        mm_out_vector_valid = 1'b1;
        tick();
        mm_out_vector_valid = 1'b0;
    endtask

    task automatic drain_scoreboard(input bit toggle);
        int guard = 0;
        bit rdy = 1'b1;
        logic [7:0] exp;
        while (out_q.size() > 0 && guard < 40) begin
            out_ready = toggle ? rdy : 1'b1;
            #0;
            if (out_valid && out_ready) begin
                exp = out_q.pop_front();
                n_vec++;
                $display("drain out_data=%0d", $signed(out_data));
                if (out_data !== exp) begin
                    n_miss++;
                    $display("FAIL drain_data: got %0d want %0d", $signed(out_data), $signed(exp));
                end
            end
            tick();
            rdy = ~rdy;
            guard++;
        end
        out_ready = 1'b0;
        n_vec++;
        if (out_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain_timeout: %0d elements left, want 0", out_q.size());
        end
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL drain_done_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic check_idle(input string tag);
        n_vec++;
        $display("%s: in_ready=%b dr=%b chunk=%h ov=%b od=%h err=%b", tag, in_ready,
                 mm_data_ready, mm_chunk, out_valid, out_data, seq_error);
        if (in_ready !== 1'b1 || mm_data_ready !== 1'b0 || mm_chunk !== 32'h0 ||
            out_valid !== 1'b0 || out_data !== 8'h0 || seq_error !== 1'b0) begin
            n_miss++;
            $display("FAIL %s: got rdy=%b dr=%b chunk=%h ov=%b od=%h err=%b want 1,0,0,0,0,0",
                     tag, in_ready, mm_data_ready, mm_chunk, out_valid, out_data, seq_error);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_idle("reset_powerup");
        feed(50, 5);
        do_reset();
        check_idle("reset_midfill");
    endtask

    task automatic test_load();
        feed(1, 7);
        n_vec++;
        if (mm_data_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL early_ready: got %b want 0", mm_data_ready);
        end
        feed(8, 1);
        n_vec++;
        $display("load: data_ready=%b in_ready=%b chunk=%h", mm_data_ready, in_ready, mm_chunk);
        if (mm_data_ready !== 1'b1 || in_ready !== 1'b0 || mm_chunk !== 32'h04030201) begin
            n_miss++;
            $display("FAIL load: got dr=%b rdy=%b chunk=%h want 1,0,04030201",
                     mm_data_ready, in_ready, mm_chunk);
        end
        pulse_chunk(1'b1, 1'b0, 32'h08070605);
        n_vec++;
        if (mm_data_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL busy_ready: got %b want 0", mm_data_ready);
        end
        pulse_chunk(1'b1, 1'b0, 32'h04030201);
    endtask

    task automatic test_ptr_rst();
        pulse_chunk(1'b1, 1'b1, 32'h04030201);
        pulse_chunk(1'b1, 1'b0, 32'h08070605);
    endtask

    task automatic test_drain();
        out_ready = 1'b0;
        strobe_out(8'hF9, 1'b0, 1'b1);
        strobe_out(8'h00, 1'b0, 1'b1);
        strobe_out(8'h7F, 1'b0, 1'b1);
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_miss++;
            $display("FAIL out_latency: got %b want 1", out_valid);
        end
        vec_valid_pulse();
        n_vec++;
        if (seq_error !== 1'b0 || in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL vec_done: got err=%b rdy=%b want 0,1", seq_error, in_ready);
        end
        drain_scoreboard(1'b1);
    endtask

    task automatic test_errors();
        do_reset();
        feed(10, 8);
        pulse_chunk(1'b1, 1'b0, 32'h11100F0E);
        strobe_out(8'd1, 1'b0, 1'b1);
        strobe_out(8'd2, 1'b0, 1'b1);
        strobe_out(8'd3, 1'b0, 1'b1);
        n_vec++;
        if (seq_error !== 1'b0) begin
            n_miss++;
            $display("FAIL err_premature: got %b want 0", seq_error);
        end
        strobe_out(8'd4, 1'b0, 1'b0);
        tick(); tick();
        n_vec++;
        if (seq_error !== 1'b1) begin
            n_miss++;
            $display("FAIL err_drain_strobe: got %b want 1", seq_error);
        end
        drain_scoreboard(1'b0);
        do_reset();
        feed(20, 8);
        pulse_chunk(1'b1, 1'b0, 32'h1B1A1918);
        strobe_out(8'd5, 1'b0, 1'b1);
        strobe_out(8'd6, 1'b1, 1'b1);
        n_vec++;
        if (seq_error !== 1'b1) begin
            n_miss++;
            $display("FAIL err_short_vector: got %b want 1", seq_error);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        feed(1, 8);
        pulse_chunk(1'b1, 1'b0, 32'h08070605);
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(9 + k);
            #0;
            n_vec++;
            if (in_ready !== PP) begin
                n_miss++;
                $display("FAIL busy_in_ready[%0d]: got %b want %b", k + 9, in_ready, PP);
            end
            tick();
        end
        in_valid = 1'b0;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL full_in_ready: got %b want 0", in_ready);
        end
        strobe_out(8'd21, 1'b0, 1'b1);
        strobe_out(8'd22, 1'b0, 1'b1);
        strobe_out(8'd23, 1'b1, 1'b1);
        n_vec++;
        if (in_ready !== 1'b1 || mm_data_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL swap: got rdy=%b dr=%b want 1,0", in_ready, mm_data_ready);
        end
        drain_scoreboard(1'b0);
        n_vec++;
        $display("after drain: data_ready=%b chunk=%h", mm_data_ready, mm_chunk);
        if (mm_data_ready !== PP || mm_chunk !== (PP ? 32'h0C0B0A09 : 32'h08070605) ||
            seq_error !== 1'b0) begin
            n_miss++;
            $display("FAIL second_vector: got dr=%b chunk=%h err=%b want %b,%h,0",
                     mm_data_ready, mm_chunk, seq_error, PP, PP ? 32'h0C0B0A09 : 32'h08070605);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_ptr_rst();
        test_drain();
        test_errors();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
